// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipe: load-use interlock, EX
// jump/branch redirect, multi-cycle mul/div sequencing and data-memory freeze.
module pipe_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_rd_en,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs2_rd_en,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_isload,
    input  logic             ex_wr_en,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_jb_flag,
    input  logic [31:0]      ex_jb_addr,
    input  logic             ex_md_req,
    input  logic             md_done,
    input  logic             mem_busy,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redirect_en,
    output logic [31:0]      redirect_pc,
    output logic             md_start,
    output logic             md_kill,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MCW = $clog2(MD_MAX_CYCLES);
    localparam logic [MCW-1:0] MD_LAST = MCW'(MD_MAX_CYCLES - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   md_cnt_q, md_cnt_d;
    logic             out_en_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             md_hold;
    logic             md_expire;

    // Mul/div handshake: md_start is a single-cycle request issued on the
    // RUN->MD_BUSY edge; md_done is a single-cycle response accepted only in
    // MD_BUSY with mem_busy low; md_kill aborts the op when the watchdog expires.

    assign load_use = ex_isload & ex_wr_en & (ex_wr_addr != 5'd0) &
                      ((id_rs1_rd_en & (id_rs1_addr == ex_wr_addr)) |
                       (id_rs2_rd_en & (id_rs2_addr == ex_wr_addr)));

    // out_en_q keeps every output quiet during reset and the first cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en_q    <= 1'b0;
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_en_q <= 1'b1;
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (stall[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall       = 5'b00000;
        flush       = 5'b00000;
        redirect_en = 1'b0;
        redirect_pc = 32'h0000_0000;
        md_start    = 1'b0;
        md_kill     = 1'b0;
        md_expire   = 1'b0;
        md_hold     = 1'b0;

        if (out_en_q) begin
            md_expire = (state_q == MD_BUSY) & ~md_done & ~mem_busy &
                        (md_cnt_q == MD_LAST);
            md_hold   = ((state_q == RUN) & ex_md_req) |
                        ((state_q == MD_BUSY) & ~md_done & ~md_expire);

            // A memory wait freezes the sequencer entirely, counter included.
            case (state_q)
                RUN: begin
                    if (ex_md_req && !mem_busy) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = '0;
                        md_start = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (!mem_busy) begin
                        if (md_done) begin
                            state_d = RUN;
                        end else if (md_expire) begin
                            state_d = RUN;
                            md_kill = 1'b1;
                        end else begin
                            md_cnt_d = md_cnt_q + MCW'(1);
                        end
                    end
                end
                default: state_d = RUN;
            endcase

            if (mem_busy) begin
                stall = 5'b11111;
            end else if (md_hold) begin
                stall = 5'b01111;
                flush = 5'b10000;
            end else if (ex_jb_flag) begin
                flush       = 5'b00110;
                redirect_en = 1'b1;
                redirect_pc = ex_jb_addr;
            end else if (load_use) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int W = 77;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_rs1_rd_en, id_rs2_rd_en;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        ex_isload, ex_wr_en, ex_jb_flag, ex_md_req, md_done, mem_busy;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_jb_addr;
  logic [4:0]  stall, flush;
  logic        redirect_en, md_start, md_kill;
  logic [31:0] redirect_pc, stall_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [31:0]  exp_cnt;
  int           checks = 0;
  int           errors = 0;

  pipe_hazard_ctrl #(.MD_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_rd_en(id_rs1_rd_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_rd_en(id_rs2_rd_en), .id_rs2_addr(id_rs2_addr),
    .ex_isload(ex_isload), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_jb_flag(ex_jb_flag), .ex_jb_addr(ex_jb_addr),
    .ex_md_req(ex_md_req), .md_done(md_done), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .md_start(md_start), .md_kill(md_kill),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle_in();
    id_rs1_rd_en = 1'b0; id_rs1_addr = 5'd0;
    id_rs2_rd_en = 1'b0; id_rs2_addr = 5'd0;
    ex_isload = 1'b0; ex_wr_en = 1'b0; ex_wr_addr = 5'd0;
    ex_jb_flag = 1'b0; ex_jb_addr = 32'h0;
    ex_md_req = 1'b0; md_done = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic exp_out(input string nm, input logic [4:0] s, input logic [4:0] f,
                         input logic ren, input logic [31:0] pc,
                         input logic st, input logic kl);
    exp_q.push_back({s, f, ren, pc, st, kl, exp_cnt});
    name_q.push_back(nm);
    if (s[0]) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic exp_clean(input string nm);
    exp_out(nm, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic exp_md_hold(input string nm, input logic st);
    exp_out(nm, 5'b01111, 5'b10000, 1'b0, 32'h0, st, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, exp;
      string nm;
      got = {stall, flush, redirect_en, redirect_pc, md_start, md_kill, stall_cnt};
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b ren=%b pc=%h start=%b kill=%b cnt=%0d | want stall=%b flush=%b ren=%b pc=%h start=%b kill=%b cnt=%0d",
                 nm, got[76:72], got[71:67], got[66], got[65:34], got[33], got[32], got[31:0],
                 exp[76:72], exp[71:67], exp[66], exp[65:34], exp[33], exp[32], exp[31:0]);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench did not finish, %0d entries pending", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    idle_in();
    rst = 1'b1;
    exp_cnt = 32'd0;

    // reset: outputs quiet even with mem_busy high
    tick(); mem_busy = 1'b1; exp_clean("reset_hold");
    tick(); mem_busy = 1'b1; exp_clean("reset_hold2");
    tick(); rst = 1'b0; mem_busy = 1'b1; exp_clean("first_cycle_after_release");
    tick(); mem_busy = 1'b1; exp_out("mem_busy", 5'b11111, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); exp_clean("idle");

    // load-use on rs2, then clean cycle
    tick(); ex_isload = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd5;
    id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd5;
    exp_out("load_use_rs2", 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd5; exp_clean("after_load_use");
    tick(); ex_isload = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd17;
    id_rs1_rd_en = 1'b1; id_rs1_addr = 5'd17;
    exp_out("load_use_rs1", 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); ex_isload = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd0;
    id_rs1_rd_en = 1'b1; id_rs2_rd_en = 1'b1;
    exp_clean("load_x0");
    tick(); ex_isload = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd9; id_rs1_addr = 5'd9;
    exp_clean("load_rs1_not_read");
    tick(); ex_isload = 1'b0; ex_wr_en = 1'b1; ex_wr_addr = 5'd9;
    id_rs1_rd_en = 1'b1; id_rs1_addr = 5'd9;
    exp_clean("non_load_writer");

    // branch redirect, alone and with a simultaneous load-use
    tick(); ex_jb_flag = 1'b1; ex_jb_addr = 32'h0000_0100;
    exp_out("branch", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    tick(); ex_jb_flag = 1'b1; ex_jb_addr = 32'h8000_0ABC;
    ex_isload = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd3;
    id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd3;
    exp_out("branch_over_load_use", 5'b00000, 5'b00110, 1'b1, 32'h8000_0ABC, 1'b0, 1'b0);
    tick(); ex_jb_flag = 1'b1; ex_jb_addr = 32'h0000_0200; mem_busy = 1'b1;
    exp_out("mem_busy_over_branch", 5'b11111, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); md_done = 1'b1; exp_clean("md_done_in_run_ignored");

    // mul/div finishing after 33 cycles; a branch in EX during the hold is masked
    tick(); ex_md_req = 1'b1; exp_md_hold("md_start", 1'b1);
    for (int k = 1; k <= 32; k++) begin
      tick(); ex_md_req = 1'b1;
      ex_jb_flag = (k == 10); ex_jb_addr = 32'h0000_0400;
      exp_md_hold("md_busy", 1'b0);
    end
    tick(); ex_md_req = 1'b1; md_done = 1'b1; exp_clean("md_done_release");
    tick(); exp_clean("md_after_done");

    // watchdog: kill 40 cycles after md_start
    tick(); ex_md_req = 1'b1; exp_md_hold("wd_start", 1'b1);
    for (int k = 1; k <= 39; k++) begin
      tick(); ex_md_req = 1'b1; exp_md_hold("wd_busy", 1'b0);
    end
    tick(); ex_md_req = 1'b1; exp_out("wd_kill", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(); md_done = 1'b1; exp_clean("wd_back_in_run");

    // watchdog with 3 mem_busy cycles: kill slips to cycle 43
    tick(); ex_md_req = 1'b1; exp_md_hold("wdm_start", 1'b1);
    for (int k = 1; k <= 42; k++) begin
      tick(); ex_md_req = 1'b1;
      if (k >= 10 && k <= 12) begin
        mem_busy = 1'b1;
        exp_out("wdm_mem_busy", 5'b11111, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0);
      end else begin
        exp_md_hold("wdm_busy", 1'b0);
      end
    end
    tick(); ex_md_req = 1'b1; exp_out("wdm_kill", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(); exp_clean("wdm_after_kill");

    // async reset in MD_BUSY
    tick(); ex_md_req = 1'b1; exp_md_hold("rst_md_start", 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(); ex_md_req = 1'b1; exp_md_hold("rst_md_busy", 1'b0);
    end
    tick(); ex_md_req = 1'b1; mem_busy = 1'b1;
    #2 rst = 1'b1;
    exp_cnt = 32'd0;
    exp_clean("async_rst_immediate");
    tick(); ex_md_req = 1'b1; exp_clean("async_rst_held");
    tick(); rst = 1'b0; ex_md_req = 1'b1; exp_clean("post_rst_first_cycle");
    tick(); ex_md_req = 1'b1; exp_md_hold("post_rst_run_start", 1'b1);
    tick(); ex_md_req = 1'b1; md_done = 1'b1; exp_clean("post_rst_done");
    tick(); exp_clean("final_idle");

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
